// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline control codes: staller encodings and the enable and zero-word constants.
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    STL_GO     = 2'b00,
    STL_STALL  = 2'b01,
    STL_BUBBLE = 2'b10
  } stl_e;

  localparam logic ENABLE    = 1'b1;
  localparam logic ZERO_WORD = 1'b0;

  // 2'b11 has no meaning of its own and is treated as a bubble, so any code with bit 1 set clears the stage.
  function automatic logic stl_is_bubble(input logic [1:0] stl);
    return stl[1];
  endfunction

endpackage

// File: rtl/pipe_skid_reg_skid_slot.sv
// One storage entry: a valid flag plus a payload register, with synchronous clear and load.
module skid_slot
  import pipe_skid_reg_pkg::*;
#(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  // Clear wins over load, so a flush in the same cycle as a push drops the word.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      valid <= ZERO_WORD;
      data  <= BUBBLE_VAL;
    end else if (load) begin
      valid <= ENABLE;
      data  <= load_data;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a valid/ready handshake, a one-entry skid buffer,
// and the staller controls GO, STALL and BUBBLE, plus an explicit flush.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        stl_i,
  input  logic              flush_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [DATA_W-1:0] dn_data_o,
  output logic [1:0]        occ_o
);

  // Handshake: a word moves on a side only in a cycle where that side's valid and ready
  // are both high at the rising edge. Ready does not depend on valid on either side.
  // Both up_ready_o and dn_valid_o are masked low during rst, flush, STALL and BUBBLE.

  logic              m_valid, s_valid;
  logic [DATA_W-1:0] m_data, s_data;
  logic              active, kill, push, pop;
  logic              m_load, m_clr, s_load, s_clr;
  logic [DATA_W-1:0] m_load_data;

  always_comb begin
    active     = (stl_i == STL_GO) && !flush_i && !rst;
    kill       = flush_i || stl_is_bubble(stl_i);
    up_ready_o = active && !s_valid;
    dn_valid_o = active && m_valid;
    push       = up_valid_i && up_ready_o;
    pop        = dn_valid_o && dn_ready_i;

    // Main is refilled from the skid entry when that entry holds the older word.
    m_load      = (push && (!m_valid || pop)) || (pop && s_valid);
    m_load_data = s_valid ? s_data : up_data_i;
    m_clr       = kill || (pop && !push && !s_valid);
    s_load      = push && m_valid && !pop;
    s_clr       = kill || (pop && s_valid);
  end

  skid_slot #(.DATA_W(DATA_W), .BUBBLE_VAL(BUBBLE_VAL)) u_main (
    .clk       (clk),
    .rst       (rst),
    .clr       (m_clr),
    .load      (m_load),
    .load_data (m_load_data),
    .valid     (m_valid),
    .data      (m_data)
  );

  skid_slot #(.DATA_W(DATA_W), .BUBBLE_VAL(BUBBLE_VAL)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clr       (s_clr),
    .load      (s_load),
    .load_data (up_data_i),
    .valid     (s_valid),
    .data      (s_data)
  );

  assign dn_data_o = m_data;
  assign occ_o     = {1'b0, m_valid} + {1'b0, s_valid};

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed steps followed by random traffic. A two-word FIFO model
// predicts the expected outputs for every cycle.
module tb_pipe_skid_reg;
  localparam int          DATA_W = 64;
  localparam logic [63:0] BUB    = 64'h0;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        stl_i;
  logic              flush_i, up_valid_i, up_ready_o, dn_valid_o, dn_ready_i;
  logic [DATA_W-1:0] up_data_i, dn_data_o;
  logic [1:0]        occ_o;

  logic [DATA_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  pipe_skid_reg #(.DATA_W(DATA_W), .BUBBLE_VAL(BUB)) dut (
    .clk        (clk),
    .rst        (rst),
    .stl_i      (stl_i),
    .flush_i    (flush_i),
    .up_valid_i (up_valid_i),
    .up_ready_o (up_ready_o),
    .up_data_i  (up_data_i),
    .dn_valid_o (dn_valid_o),
    .dn_ready_i (dn_ready_i),
    .dn_data_o  (dn_data_o),
    .occ_o      (occ_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, checks the outputs against the model, then advances the model.
  task automatic cycle(input logic r, input logic [1:0] s, input logic f,
                       input logic uv, input logic [63:0] ud, input logic dr);
    logic kill, e_ready, e_valid, do_push, do_pop;
    logic [63:0] e_data;
    rst = r; stl_i = s; flush_i = f; up_valid_i = uv; up_data_i = ud; dn_ready_i = dr;
    kill    = r || f || s[1];
    e_ready = !kill && (s == 2'b00) && (exp_q.size() < 2);
    e_valid = !kill && (s == 2'b00) && (exp_q.size() > 0);
    e_data  = (exp_q.size() > 0) ? exp_q[0] : BUB;
    #2;
    chk("up_ready", {63'b0, up_ready_o}, {63'b0, e_ready});
    chk("dn_valid", {63'b0, dn_valid_o}, {63'b0, e_valid});
    chk("dn_data", dn_data_o, e_data);
    chk("occ", {62'b0, occ_o}, 64'(exp_q.size()));
    do_pop  = e_valid && dr;
    do_push = e_ready && uv;
    @(posedge clk);
    if (kill) exp_q.delete();
    else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(ud);
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; stl_i = 2'b00; flush_i = 1'b0; up_valid_i = 1'b0;
    up_data_i = '0; dn_ready_i = 1'b0;
    @(posedge clk);
    #1;
    // Reset is held for a second cycle: outputs must be masked and the state must be cleared.
    cycle(1, 2'b00, 0, 1, 64'h99, 1);

    // Stream at full throughput.
    cycle(0, 2'b00, 0, 1, 64'h11, 1);
    cycle(0, 2'b00, 0, 1, 64'h22, 1);
    cycle(0, 2'b00, 0, 1, 64'h33, 1);
    cycle(0, 2'b00, 0, 0, 64'h0, 1);

    // Back-pressure fills the skid entry.
    cycle(0, 2'b00, 0, 1, 64'hA1, 0);
    cycle(0, 2'b00, 0, 1, 64'hA2, 0);
    cycle(0, 2'b00, 0, 1, 64'hA3, 0);
    // STALL with both entries full, then drain.
    for (int i = 0; i < 3; i++) cycle(0, 2'b01, 0, 1, 64'hB0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 2'b00, 0, 0, 64'h0, 1);

    // Flush with both entries full and an upstream word offered.
    cycle(0, 2'b00, 0, 1, 64'hC1, 0);
    cycle(0, 2'b00, 0, 1, 64'hC2, 0);
    cycle(0, 2'b00, 1, 1, 64'hFF, 1);
    cycle(0, 2'b00, 0, 0, 64'h0, 1);

    // Code 2'b11 behaves as BUBBLE.
    cycle(0, 2'b00, 0, 1, 64'hD1, 0);
    cycle(0, 2'b11, 0, 1, 64'hD2, 1);
    cycle(0, 2'b00, 0, 0, 64'h0, 1);

    // Reset mid-stream with both entries full.
    cycle(0, 2'b00, 0, 1, 64'hE1, 0);
    cycle(0, 2'b00, 0, 1, 64'hE2, 0);
    cycle(1, 2'b00, 0, 1, 64'hE3, 1);
    cycle(0, 2'b00, 0, 1, 64'hF1, 1);
    cycle(0, 2'b00, 0, 0, 64'h0, 1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      int sel;
      logic [1:0] s;
      sel = $urandom_range(0, 15);
      s = (sel == 0) ? 2'b01 : (sel == 1) ? 2'b10 : (sel == 2) ? 2'b11 : 2'b00;
      cycle(($urandom_range(0, 49) == 0), s, ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 3) != 0), {$urandom, $urandom},
            ($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
